// File: rtl/matmul_controller_pkg.sv
// rtl/matmul_controller_pkg.sv - shared FSM states and default sizes for the matmul controller
package matmul_controller_pkg;
  localparam int DEF_N      = 10;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    MAC,
    STORE,
    DONE
  } state_t;
endpackage

// File: rtl/matmul_controller_mac_unit.sv
// rtl/matmul_controller_mac_unit.sv - unsigned multiply-accumulate, wraps modulo 2^ACC_W
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/matmul_controller.sv
// rtl/matmul_controller.sv - sequences R = A x B over registered-read memories and requests R transmission
module matmul_controller
  import matmul_controller_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              a_loaded,
  input  logic              b_loaded,
  output logic              rd_en_a,
  output logic [ADDR_W-1:0] rd_addr_a,
  input  logic [DATA_W-1:0] rd_data_a,
  output logic              rd_en_b,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              wr_en_r,
  output logic [ADDR_W-1:0] wr_addr_r,
  output logic [ACC_W-1:0]  wr_data_r,
  output logic              read_r_mat,
  output logic              complete
);
  localparam int CW = $clog2(N + 1);

  state_t        state, next_state;
  logic [CW-1:0] i, j, k;
  logic [ACC_W-1:0] acc;
  logic          done_seen;
  logic          row_valid;
  logic          k_last;
  logic          j_last;

  assign row_valid = (i != CW'(N));
  assign k_last    = (k == CW'(N - 1));
  assign j_last    = (j == CW'(N - 1));

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rd_en_a    = 1'b0;
    rd_en_b    = 1'b0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    wr_en_r    = 1'b0;
    wr_addr_r  = '0;
    wr_data_r  = '0;
    read_r_mat = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE:  if (a_loaded && b_loaded) next_state = START;
      START: next_state = LOAD;
      LOAD: begin
        if (row_valid) begin
          next_state = MAC;
          rd_en_a    = 1'b1;
          rd_en_b    = 1'b1;
          rd_addr_a  = ADDR_W'(N * int'(i) + int'(k));
          rd_addr_b  = ADDR_W'(N * int'(k) + int'(j));
        end else begin
          next_state = DONE;
        end
      end
      MAC:   next_state = k_last ? STORE : LOAD;
      STORE: begin
        next_state = LOAD;
        wr_en_r    = 1'b1;
        wr_addr_r  = ADDR_W'(N * int'(i) + int'(j));
        wr_data_r  = acc;
      end
      DONE: begin
        complete   = 1'b1;
        read_r_mat = !done_seen;
      end
      default: next_state = IDLE;
    endcase
  end

  // k holds at N-1 through MAC so STORE sees the final index; STORE rewinds it
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      i         <= '0;
      j         <= '0;
      k         <= '0;
      done_seen <= 1'b0;
    end else begin
      case (state)
        START: begin
          i         <= '0;
          j         <= '0;
          k         <= '0;
          done_seen <= 1'b0;
        end
        MAC: if (!k_last) k <= k + CW'(1);
        STORE: begin
          k <= '0;
          if (j_last) begin
            j <= '0;
            i <= i + CW'(1);
          end else begin
            j <= j + CW'(1);
          end
        end
        DONE:    done_seen <= 1'b1;
        default: ;
      endcase
    end
  end

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .slow_clk(slow_clk),
    .rst     (rst),
    .clear   ((state == START) || (state == STORE)),
    .en      (state == MAC),
    .a       (rd_data_a),
    .b       (rd_data_b),
    .acc     (acc)
  );
endmodule

// File: tb/tb_matmul_controller.sv
// tb/tb_matmul_controller.sv - scoreboard bench for N=2 and N=10 controllers with registered-read memories
module tb_matmul_controller;
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic slow_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 slow_clk = ~slow_clk;

  logic        a_ld_s, b_ld_s, rd_en_a_s, rd_en_b_s, wr_en_r_s, read_r_mat_s, complete_s;
  logic [31:0] rd_addr_a_s, rd_addr_b_s, wr_addr_r_s;
  logic [7:0]  rd_data_a_s, rd_data_b_s;
  logic [15:0] wr_data_r_s;
  logic        a_ld_l, b_ld_l, rd_en_a_l, rd_en_b_l, wr_en_r_l, read_r_mat_l, complete_l;
  logic [31:0] rd_addr_a_l, rd_addr_b_l, wr_addr_r_l;
  logic [7:0]  rd_data_a_l, rd_data_b_l;
  logic [15:0] wr_data_r_l;

  logic [7:0] ma_s [0:3];
  logic [7:0] mb_s [0:3];
  logic [7:0] ma_l [0:127];
  logic [7:0] mb_l [0:127];

  wr_t q_s[$];
  wr_t q_l[$];
  int  nwr_l = 0, nrr_s = 0, nrr_l = 0, nstb_l = 0;

  logic [8:0] out_s, out_l;
  assign out_s = {rd_en_a_s, rd_en_b_s, wr_en_r_s, read_r_mat_s, complete_s,
                  |rd_addr_a_s, |rd_addr_b_s, |wr_addr_r_s, |wr_data_r_s};
  assign out_l = {rd_en_a_l, rd_en_b_l, wr_en_r_l, read_r_mat_l, complete_l,
                  |rd_addr_a_l, |rd_addr_b_l, |wr_addr_r_l, |wr_data_r_l};

  matmul_controller #(.N(2)) dut_s (
    .slow_clk(slow_clk), .rst(rst), .a_loaded(a_ld_s), .b_loaded(b_ld_s),
    .rd_en_a(rd_en_a_s), .rd_addr_a(rd_addr_a_s), .rd_data_a(rd_data_a_s),
    .rd_en_b(rd_en_b_s), .rd_addr_b(rd_addr_b_s), .rd_data_b(rd_data_b_s),
    .wr_en_r(wr_en_r_s), .wr_addr_r(wr_addr_r_s), .wr_data_r(wr_data_r_s),
    .read_r_mat(read_r_mat_s), .complete(complete_s)
  );

  matmul_controller #(.N(10)) dut_l (
    .slow_clk(slow_clk), .rst(rst), .a_loaded(a_ld_l), .b_loaded(b_ld_l),
    .rd_en_a(rd_en_a_l), .rd_addr_a(rd_addr_a_l), .rd_data_a(rd_data_a_l),
    .rd_en_b(rd_en_b_l), .rd_addr_b(rd_addr_b_l), .rd_data_b(rd_data_b_l),
    .wr_en_r(wr_en_r_l), .wr_addr_r(wr_addr_r_l), .wr_data_r(wr_data_r_l),
    .read_r_mat(read_r_mat_l), .complete(complete_l)
  );

  always @(posedge slow_clk) begin
    if (rd_en_a_s) rd_data_a_s <= ma_s[rd_addr_a_s[1:0]];
    if (rd_en_b_s) rd_data_b_s <= mb_s[rd_addr_b_s[1:0]];
    if (rd_en_a_l) rd_data_a_l <= ma_l[rd_addr_a_l[6:0]];
    if (rd_en_b_l) rd_data_b_l <= mb_l[rd_addr_b_l[6:0]];
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a write
  initial begin
    wr_t e;
    forever begin
      @(negedge slow_clk);
      nrr_s += int'(read_r_mat_s);
      nrr_l += int'(read_r_mat_l);
      if (rd_en_a_l || rd_en_b_l || wr_en_r_l) nstb_l++;
      if (wr_en_r_s) begin
        chk(!rd_en_a_s && !rd_en_b_s, "s_no_overlap", int'(rd_en_a_s), 0);
        if (q_s.size() == 0) chk(1'b0, "s_unexpected_write", int'(wr_addr_r_s), -1);
        else begin
          e = q_s.pop_front();
          chk(int'(wr_addr_r_s) == e.addr, "s_wr_addr", int'(wr_addr_r_s), e.addr);
          chk(int'(wr_data_r_s) == e.data, "s_wr_data", int'(wr_data_r_s), e.data);
        end
      end
      if (wr_en_r_l) begin
        nwr_l++;
        chk(!rd_en_a_l && !rd_en_b_l, "l_no_overlap", int'(rd_en_a_l), 0);
        if (q_l.size() == 0) chk(1'b0, "l_unexpected_write", int'(wr_addr_r_l), -1);
        else begin
          e = q_l.pop_front();
          chk(int'(wr_addr_r_l) == e.addr, "l_wr_addr", int'(wr_addr_r_l), e.addr);
          chk(int'(wr_data_r_l) == e.data, "l_wr_data", int'(wr_data_r_l), e.data);
        end
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge slow_clk);
    @(negedge slow_clk);
    rst = 1'b0;
  endtask

  task automatic wait_complete(input bit big, input int exp_edges, input string name);
    int edges = 0;
    bit seen  = 1'b0;
    while (!seen && edges < exp_edges + 40) begin
      @(posedge slow_clk);
      #1;
      edges++;
      seen = big ? complete_l : complete_s;
    end
    chk(seen && edges == exp_edges, name, edges, exp_edges);
  endtask

  task automatic push_s_case1(input int count);
    int r[4] = '{19, 22, 43, 50};
    for (int x = 0; x < count; x++) q_s.push_back('{addr: x, data: r[x]});
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    a_ld_s = 0; b_ld_s = 0; a_ld_l = 0; b_ld_l = 0;
    for (int x = 0; x < 4; x++) begin
      ma_s[x] = 8'(x + 1);
      mb_s[x] = 8'(x + 5);
    end
    repeat (3) @(negedge slow_clk);
    chk(out_s == 9'd0, "reset_outputs_s", int'(out_s), 0);
    chk(out_l == 9'd0, "reset_outputs_l", int'(out_l), 0);
    rst = 1'b0;

    // N=2 product
    push_s_case1(4);
    nrr_s = 0;
    @(negedge slow_clk);
    a_ld_s = 1; b_ld_s = 1;
    wait_complete(1'b0, 23, "n2_complete_edges");
    repeat (4) @(negedge slow_clk);
    chk(nrr_s == 1, "n2_read_r_mat_pulses", nrr_s, 1);
    chk(complete_s == 1'b1, "n2_complete_holds", int'(complete_s), 1);
    chk(q_s.size() == 0, "n2_all_written", q_s.size(), 0);

    // Reset during the third STORE, then rerun
    a_ld_s = 0; b_ld_s = 0;
    pulse_reset();
    push_s_case1(2);
    a_ld_s = 1; b_ld_s = 1;
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 3; c++) begin
      @(posedge slow_clk);
      #1;
      if (wr_en_r_s) cnt++;
    end
    chk(cnt == 3, "third_store_reached", cnt, 3);
    rst = 1'b1;
    #1;
    chk(out_s == 9'd0, "midrun_reset_outputs", int'(out_s), 0);
    @(negedge slow_clk);
    rst = 1'b0;
    push_s_case1(4);
    nrr_s = 0;
    wait_complete(1'b0, 23, "rerun_complete_edges");
    repeat (3) @(negedge slow_clk);
    chk(nrr_s == 1, "rerun_read_r_mat_pulses", nrr_s, 1);
    chk(q_s.size() == 0, "rerun_all_written", q_s.size(), 0);
    a_ld_s = 0; b_ld_s = 0;

    // N=10 identity x address-valued B
    for (int x = 0; x < 100; x++) begin
      ma_l[x] = ((x / 10) == (x % 10)) ? 8'd1 : 8'd0;
      mb_l[x] = 8'(x);
      q_l.push_back('{addr: x, data: x});
    end
    nwr_l = 0;
    @(negedge slow_clk);
    a_ld_l = 1; b_ld_l = 1;
    wait_complete(1'b1, 2103, "identity_complete_edges");
    @(negedge slow_clk);
    chk(nwr_l == 100, "identity_write_count", nwr_l, 100);
    chk(q_l.size() == 0, "identity_all_written", q_l.size(), 0);

    // N=10 all 255: wraps to 60426
    a_ld_l = 0; b_ld_l = 0;
    pulse_reset();
    for (int x = 0; x < 100; x++) begin
      ma_l[x] = 8'd255;
      mb_l[x] = 8'd255;
      q_l.push_back('{addr: x, data: 60426});
    end
    nrr_l = 0;
    a_ld_l = 1; b_ld_l = 1;
    wait_complete(1'b1, 2103, "wrap_complete_edges");
    @(negedge slow_clk);
    chk(q_l.size() == 0, "wrap_all_written", q_l.size(), 0);
    chk(nrr_l == 1, "wrap_read_r_mat_pulses", nrr_l, 1);

    // Only A loaded: must idle; then all-ones run with flags dropped mid-run
    a_ld_l = 0; b_ld_l = 0;
    pulse_reset();
    for (int x = 0; x < 100; x++) begin
      ma_l[x] = 8'd1;
      mb_l[x] = 8'd1;
      q_l.push_back('{addr: x, data: 10});
    end
    nstb_l = 0;
    a_ld_l = 1;
    repeat (50) @(negedge slow_clk);
    chk(nstb_l == 0, "a_only_no_strobes", nstb_l, 0);
    chk(complete_l == 1'b0, "a_only_not_complete", int'(complete_l), 0);
    b_ld_l = 1;
    @(posedge slow_clk);
    #1;
    chk(rd_en_a_l == 1'b0, "start_cycle_no_strobe", int'(rd_en_a_l), 0);
    @(posedge slow_clk);
    #1;
    chk(rd_en_a_l && rd_en_b_l, "first_load_strobes", int'(rd_en_a_l), 1);
    a_ld_l = 0; b_ld_l = 0;
    wait_complete(1'b1, 2101, "ones_complete_edges");
    @(negedge slow_clk);
    chk(q_l.size() == 0, "ones_all_written", q_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
